// File: rtl/xpmwrap_sdpram_stream_reader.sv
// xpmwrap_sdpram_stream_reader
// Read-side controller for port B of the common-clock simple dual-port RAM
// wrapper. Accepts read addresses on a valid/ready stream, drives
// addrb/enb/regceb, follows each read through the RAM's fixed pipeline and
// returns the data in request order through a small output FIFO.
//
// Requests are only accepted while a FIFO slot is guaranteed for the word.
// Because of that, the RAM pipeline never has to stall, and backpressure on
// the output can never drop a word.
module xpmwrap_sdpram_stream_reader #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clka,
    input  logic                  rstb,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [READ_LATENCY:1] v;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [CW:0]           credit_used;
    logic                  issue;
    logic                  land;
    logic                  push;
    logic                  pop;

    // A credit is the sum of reads still in the RAM pipe and words waiting
    // in the FIFO. Both terms are registered, so a pop only returns its
    // credit on the following cycle.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign req_ready   = !rstb && !flush && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign issue       = req_valid && req_ready;

    assign ram_enb   = issue;
    assign ram_addrb = req_addr;

    // A word is on doutb in the cycle the valid tag reaches the end of the
    // pipe. During a flush it is dropped rather than written.
    assign land = v[READ_LATENCY];
    assign push = land && !flush;

    // The flush cycle hides the head word, so nothing can be popped then.
    assign m_valid = (fifo_count != '0) && !flush;
    assign m_data  = fifo_mem[rd_ptr];
    assign pop     = m_valid && m_ready;

    // regceb enables the RAM output register one cycle before the data is
    // due. With a single-cycle RAM there is no output register to enable.
    generate
        if (READ_LATENCY == 1) begin : g_rl1
            assign ram_regceb = !rstb;
        end else begin : g_rln
            assign ram_regceb = v[READ_LATENCY-1];
        end
    endgenerate

    // Valid tags that follow each issued read through the RAM pipeline.
    always_ff @(posedge clka or posedge rstb) begin
        if (rstb) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            v[1] <= issue;
            for (int k = 2; k <= READ_LATENCY; k++) begin
                v[k] <= v[k-1];
            end
        end
    end

    // Number of reads in the pipe, which always equals the popcount of v.
    always_ff @(posedge clka or posedge rstb) begin
        if (rstb) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(land);
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because the
    // depth is a power of two.
    always_ff @(posedge clka or posedge rstb) begin
        if (rstb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage. It has no reset because the contents are only read
    // while the count is non-zero.
    always_ff @(posedge clka) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ram_doutb;
        end
    end

    // The credit check guarantees that a landing word always finds a free slot.
    a_no_push_when_full: assert property (
        @(posedge clka) disable iff (rstb)
        !(push && (fifo_count == CW'(FIFO_DEPTH)))
    );

endmodule

// File: tb/tb_xpmwrap_sdpram_stream_reader.sv
// Bench for xpmwrap_sdpram_stream_reader, with a behavioural 2-cycle RAM
// model on port B and an in-order scoreboard of the expected words.
module tb_xpmwrap_sdpram_stream_reader;

    logic        clk;
    logic        rstb;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_addr;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [5:0]  ram_addrb;
    logic        ram_enb;
    logic        ram_regceb;
    logic [31:0] ram_doutb;

    logic [31:0] tbmem [64];
    logic [31:0] ram_r1;
    logic [31:0] sb [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int phase = 0;
    int pops_total = 0;
    int stream_pops = 0;
    int last_pop_cyc = 0;

    xpmwrap_sdpram_stream_reader #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clka(clk), .rstb(rstb), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_regceb(ram_regceb),
        .ram_doutb(ram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port B model: the enb stage reads the array, and the regceb stage
    // loads the output register.
    always @(posedge clk) begin
        if (ram_enb) ram_r1 <= tbmem[ram_addrb];
        if (ram_regceb) ram_doutb <= ram_r1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on acceptance, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rstb || flush) begin
            sb.delete();
        end else begin
            if (req_valid && req_ready) sb.push_back(tbmem[req_addr]);
            if (m_valid && m_ready) begin
                chk("data", {32'h0, m_data}, (sb.size() != 0) ? {32'h0, sb.pop_front()} : 64'hx);
                pops_total++;
                if (phase == 3) begin
                    if (stream_pops > 0) chk("stream_gap", cyc - last_pop_cyc, 1);
                    last_pop_cyc = cyc;
                    stream_pops++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (sb.size() == 0 && !m_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_drain_done"}, done, 1);
        chk({tag, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int acc;
        int p0;

        for (int i = 0; i < 64; i++) tbmem[i] = 32'(i);

        // 1. Reset: outputs gated while in reset, then idle after release.
        rstb = 1'b1; flush = 1'b0; req_valid = 1'b1; req_addr = 6'd3; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_enb", ram_enb, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_regceb", ram_regceb, 0);
        step();
        rstb = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_mvalid", m_valid, 0);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_enb", ram_enb, 0);

        // 2. Single read with exact cycle timing.
        tbmem[5] = 32'hDEADBEEF;
        step(); req_valid = 1'b1; req_addr = 6'd5;
        @(negedge clk);
        chk("single_enb", ram_enb, 1);
        chk("single_addrb", ram_addrb, 5);
        chk("single_mvalid_t0", m_valid, 0);
        step(); req_valid = 1'b0;
        @(negedge clk);
        chk("single_regceb_t1", ram_regceb, 1);
        chk("single_mvalid_t1", m_valid, 0);
        step();
        @(negedge clk);
        chk("single_mvalid_t2", m_valid, 0);
        step();
        @(negedge clk);
        chk("single_mvalid_t3", m_valid, 1);
        chk("single_mdata_t3", m_data, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("single_mvalid_t4", m_valid, 0);
        tbmem[5] = 32'd5;

        // 3. Back-to-back streaming of addresses 0..63.
        phase = 3;
        for (int i = 0; i < 64; i++) begin
            step(); req_valid = 1'b1; req_addr = 6'(i);
            @(negedge clk);
            chk("stream_ready", req_ready, 1);
        end
        step(); req_valid = 1'b0;
        drain("stream");
        chk("stream_count", stream_pops, 64);
        phase = 0;

        // 4. Backpressure: exactly four credits, then resume with no loss.
        p0 = pops_total;
        m_ready = 1'b0; a = 0; acc = 0;
        for (int i = 0; i < 10; i++) begin
            step(); req_valid = 1'b1; req_addr = 6'(a);
            @(negedge clk);
            if (req_ready) begin acc++; a++; end
        end
        chk("bp_accepted", acc, 4);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_mvalid", m_valid, 1);
        chk("bp_head", m_data, 32'd0);
        for (int i = 0; i < 40; i++) begin
            step(); m_ready = 1'b1; req_valid = (a < 12); req_addr = 6'(a);
            @(negedge clk);
            if (req_valid && req_ready) a++;
        end
        step(); req_valid = 1'b0;
        drain("bp");
        chk("bp_resume_addr", a, 12);
        chk("bp_count", pops_total - p0, 12);

        // 5. Flush with two reads in flight and one word in the FIFO.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); req_valid = 1'b1; req_addr = 6'(10 + i);
            @(negedge clk);
            chk("fl_pre_accept", req_ready, 1);
        end
        step(); req_valid = 1'b1; req_addr = 6'd13; flush = 1'b1;
        @(negedge clk);
        chk("fl_mvalid", m_valid, 0);
        chk("fl_ready", req_ready, 0);
        chk("fl_enb", ram_enb, 0);
        p0 = pops_total;
        step(); flush = 1'b0; req_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("fl_after_mvalid", m_valid, 0);
            step();
        end
        req_valid = 1'b1; req_addr = 6'd7;
        @(negedge clk);
        chk("fl_req7_accept", req_ready, 1);
        step(); req_valid = 1'b0;
        drain("fl");
        chk("fl_pops", pops_total - p0, 1);

        // 6. Asynchronous reset in the middle of streaming.
        for (int i = 0; i < 6; i++) begin
            step(); req_valid = 1'b1; req_addr = 6'(30 + i);
            @(negedge clk);
        end
        @(posedge clk);
        #3;
        rstb = 1'b1;
        #1;
        chk("arst_mvalid", m_valid, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_enb", ram_enb, 0);
        @(negedge clk);
        step(); rstb = 1'b0; req_valid = 1'b0;
        p0 = pops_total;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_after_mvalid", m_valid, 0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 6'(20 + i);
            @(negedge clk);
            chk("arst_accept", req_ready, 1);
            step();
        end
        req_valid = 1'b0;
        drain("arst");
        chk("arst_pops", pops_total - p0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
